// File: rtl/uart_block_sender_pkg.sv
// uart_block_sender_pkg: shared state encoding and constants for the UART block sender
package uart_block_sender_pkg;
    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE
    } state_t;
    localparam int SETTLE_CYCLES  = 4;
    localparam int NBYTES_DEFAULT = 16;
endpackage

// File: rtl/uart_block_sender.sv
// uart_block_sender: streams NBYTES-byte blocks MSB-first into a byte UART transmitter
module uart_block_sender
    import uart_block_sender_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                blk_valid,
    input  logic [8*NBYTES-1:0] blk_data,
    output logic                blk_ready,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_done,
    input  logic                tx_busy,
    output logic                busy,
    output logic                done
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    state_t        state_q, state_d;
    logic [W-1:0]  act_q, act_d, pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          tx_start_q, tx_start_d, done_q, done_d;
    logic          acc, last;

    // state register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SETTLE;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cnt_q       <= '0;
            settle_q    <= '0;
            tx_start_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            tx_start_q  <= tx_start_d;
            done_q      <= done_d;
        end
    end

    // next state: settle after reset, load/promote blocks, issue and shift bytes
    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        cnt_d       = cnt_q;
        settle_d    = '0;
        tx_start_d  = 1'b0;
        done_d      = 1'b0;
        acc         = blk_valid & ~pend_full_q & (state_q != ST_SETTLE);
        last        = (cnt_q == CW'(NBYTES - 1));
        case (state_q)
            ST_SETTLE: begin
                settle_d = tx_busy ? '0 : settle_q + 1'b1;
                if (!tx_busy && settle_q == SW'(SETTLE_CYCLES - 1))
                    state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (pend_full_q) begin
                    act_d       = pend_q;
                    pend_d      = '0;
                    pend_full_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_ISSUE;
                end else if (acc) begin
                    act_d   = blk_data;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (en && !tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done && !last) begin
                    act_d = act_q << 8;
                    cnt_d = cnt_q + 1'b1;
                    // a byte is only launched back-to-back while en is high; otherwise it waits in ISSUE
                    tx_start_d = en;
                    state_d    = en ? ST_WAIT_DONE : ST_ISSUE;
                end else if (tx_done) begin
                    done_d = 1'b1;
                    if (pend_full_q) begin
                        act_d       = pend_q;
                        pend_d      = '0;
                        pend_full_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_SETTLE;
        endcase
        // blocks arriving while one is active wait in the pending slot; the promoted block is never touched
        if (acc && state_q != ST_IDLE) begin
            pend_d      = blk_data;
            pend_full_d = 1'b1;
        end
    end

    // outputs decoded from registered state
    always_comb begin
        blk_ready = ~pend_full_q & (state_q != ST_SETTLE);
        busy      = (state_q == ST_ISSUE) | (state_q == ST_WAIT_DONE);
        tx_start  = tx_start_q;
        done      = done_q;
        tx_data   = act_q[W-1 -: 8];
    end
endmodule

// File: tb/tb_uart_block_sender.sv
// tb_uart_block_sender: scoreboard bench with a behavioural UART transmitter model
module tb_uart_block_sender;
    localparam int NB = 16;
    localparam int W  = 8 * NB;
    localparam int SETTLE = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic         blk_valid = 1'b0;
    logic [W-1:0] blk_data = '0;
    logic         blk_ready, tx_start, busy, done;
    logic [7:0]   tx_data;
    logic         tx_done, tx_busy;

    logic m_busy = 1'b0, m_done = 1'b0, ext_done = 1'b0;
    int   m_left = 0, n_overlap = 0;
    assign tx_busy = m_busy;
    assign tx_done = m_done | ext_done;

    logic [7:0] exp_q[$];
    int n_checks = 0, n_fail = 0, n_done = 0, exp_done = 0, sent = 0;
    logic prev_done = 1'b0, rand_en = 1'b0;

    uart_block_sender #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst), .en(en), .blk_valid(blk_valid), .blk_data(blk_data),
        .blk_ready(blk_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .tx_busy(tx_busy), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // transmitter model: a frame of random length, ending with a one-cycle done as busy drops
    initial forever begin
        @(negedge clk);
        m_done = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_busy = 1'b0;
            end
        end
        if (tx_start && en) begin
            if (m_busy) n_overlap++;
            m_busy = 1'b1;
            m_left = $urandom_range(3, 10);
        end
    end

    // monitor: every byte start is popped from the scoreboard, every done must close a full block
    initial forever begin
        @(negedge clk);
        #2;
        if (rst) begin
            sent = 0;
            prev_done = 1'b0;
        end else begin
            if (tx_start) begin
                check("start_with_en", en, 1'b1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tx_start: data %0h with empty scoreboard at %0t", tx_data, $time);
                end else begin
                    check("tx_data", tx_data, exp_q.pop_front());
                    sent++;
                end
            end
            if (done) begin
                check("done_after_block", sent, NB);
                check("done_one_cycle", prev_done, 1'b0);
                sent = 0;
                n_done++;
            end
            prev_done = done;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (rand_en && !tx_start) en = ($urandom_range(0, 3) != 0);
    endtask

    function automatic logic [W-1:0] rand_blk();
        logic [W-1:0] d;
        for (int i = 0; i < NB; i++) d[8*i +: 8] = 8'($urandom);
        return d;
    endfunction

    task automatic offer(input logic [W-1:0] d);
        blk_valid = 1'b1;
        blk_data  = d;
        for (int i = 0; i < 3000 && !blk_ready; i++) tick();
        check("offer_accepted", blk_ready, 1'b1);
        if (blk_ready) begin
            for (int i = 0; i < NB; i++) exp_q.push_back(d[W-1-8*i -: 8]);
            exp_done++;
        end
        tick();
        blk_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (n_done == exp_done && !busy && exp_q.size() == 0) break;
            tick();
        end
        check("drain_within_budget", i < 3000, 1'b1);
        check("busy_low_after", busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] d;
        int cnt, gap, low_run;
        // reset state and settle window
        tick();
        tick();
        check("rst_blk_ready", blk_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        rst = 1'b0;
        repeat (SETTLE - 1) tick();
        check("settle_early_ready", blk_ready, 1'b0);
        tick();
        check("settle_ready", blk_ready, 1'b1);

        // single block 00..0F
        for (int i = 0; i < NB; i++) d[W-1-8*i -: 8] = 8'(i);
        offer(d);
        wait_idle();

        // back-to-back blocks A and B
        offer({NB{8'h11}});
        offer({NB{8'h22}});
        check("ready_low_pending_full", blk_ready, 1'b0);
        for (cnt = 0; cnt < 2000 && !done; cnt++) tick();
        check("first_done_seen", done, 1'b1);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!tx_start && gap < 10);
        check("b2b_gap_ok", gap <= 1, 1'b1);
        wait_idle();

        // en gating in ISSUE
        en = 1'b0;
        d = rand_blk();
        offer(d);
        for (int i = 0; i < 20; i++) begin
            check("gated_no_start", tx_start, 1'b0);
            check("gated_data_held", tx_data, d[W-1 -: 8]);
            tick();
        end
        en = 1'b1;
        tick();
        check("start_after_en", tx_start, 1'b1);
        wait_idle();

        // reset in the middle of a block while a frame is in flight
        offer(rand_blk());
        cnt = 0;
        for (int i = 0; i < 2000 && cnt < 6; i++) begin
            tick();
            if (tx_start) cnt++;
        end
        check("reached_byte5", cnt, 6);
        tick();
        rst = 1'b1;
        exp_q.delete();
        exp_done--;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", blk_ready, 1'b0);
        low_run = tx_busy ? 0 : 1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (blk_ready) break;
            low_run = tx_busy ? 0 : low_run + 1;
        end
        check("midrst_ready_rises", blk_ready, 1'b1);
        check("midrst_settle_len", low_run, SETTLE);
        offer(rand_blk());
        wait_idle();

        // spurious tx_done in IDLE and in ISSUE
        ext_done = 1'b1;
        tick();
        ext_done = 1'b0;
        tick();
        check("spur_idle_busy", busy, 1'b0);
        check("spur_idle_ready", blk_ready, 1'b1);
        en = 1'b0;
        d = rand_blk();
        offer(d);
        ext_done = 1'b1;
        tick();
        ext_done = 1'b0;
        tick();
        check("spur_issue_busy", busy, 1'b1);
        check("spur_issue_start", tx_start, 1'b0);
        check("spur_issue_data", tx_data, d[W-1 -: 8]);
        en = 1'b1;
        wait_idle();

        // randomized blocks with random gaps and en toggling
        rand_en = 1'b1;
        for (int b = 0; b < 6; b++) begin
            repeat ($urandom_range(0, 20)) tick();
            offer(rand_blk());
        end
        wait_idle();
        rand_en = 1'b0;
        en = 1'b1;
        repeat (3) tick();

        check("done_count", n_done, exp_done);
        check("scoreboard_empty", exp_q.size(), 0);
        check("no_start_while_tx_busy", n_overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
